// File: rtl/uc_hold_pkg.sv
// rtl/uc_hold_pkg.sv - shared constants for the hold-channel bank
package uc_hold_pkg;

   localparam logic MODE_IGNORE = 1'b0;
   localparam logic MODE_RETRIG = 1'b1;

   // Smallest usable fallback length; zero would make a trigger a no-op.
   localparam int MIN_DEFAULT_LEN = 1;

   function automatic bit default_len_ok(input int default_len, input int cnt_w);
      return (default_len >= MIN_DEFAULT_LEN) && (default_len < (1 << cnt_w));
   endfunction

endpackage

// File: rtl/uc_hold_chan.sv
// rtl/uc_hold_chan.sv - one hold channel: trigger edge detect, hold counter, done pulse
module uc_hold_chan
   import uc_hold_pkg::*;
#(
   parameter int CNT_W       = 2,
   parameter int DEFAULT_LEN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trig,
   input  logic [CNT_W-1:0] len,
   input  logic             retrig,
   input  logic             flush,
   output logic             hold,
   output logic             done
);

   logic             trig_prev;
   logic [CNT_W-1:0] cnt;
   logic             trig_edge;
   logic             do_load;
   logic [CNT_W-1:0] load_val;

   assign trig_edge = trig & ~trig_prev;
   assign load_val  = (len != '0) ? len : CNT_W'(DEFAULT_LEN);
   assign do_load   = trig_edge && ((cnt == '0) || (retrig == MODE_RETRIG));
   assign hold      = (cnt != '0);

   // Only a natural 1->0 decrement produces done; reload and flush bypass it.
   always_ff @(posedge clk) begin
      if (reset) begin
         trig_prev <= 1'b1;
         cnt       <= '0;
         done      <= 1'b0;
      end else begin
         trig_prev <= trig;
         done      <= 1'b0;
         if (flush) begin
            cnt <= '0;
         end else if (do_load) begin
            cnt <= load_val;
         end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(1));
         end
      end
   end

endmodule

// File: rtl/uc_hold_bank.sv
// rtl/uc_hold_bank.sv - bank of independent retriggerable hold channels
module uc_hold_bank
   import uc_hold_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 2,
   parameter int DEFAULT_LEN = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       trig,
   input  logic [NUM_CH*CNT_W-1:0] len,
   input  logic [NUM_CH-1:0]       retrig,
   input  logic                    flush,
   output logic [NUM_CH-1:0]       hold,
   output logic [NUM_CH-1:0]       done,
   output logic                    hold_any
);

   generate
      if (!default_len_ok(DEFAULT_LEN, CNT_W)) begin : g_bad_default_len
         $error("uc_hold_bank: DEFAULT_LEN must be in 1..2^CNT_W-1");
      end
   endgenerate

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      uc_hold_chan #(
         .CNT_W       (CNT_W),
         .DEFAULT_LEN (DEFAULT_LEN)
      ) u_chan (
         .clk    (clk),
         .reset  (reset),
         .trig   (trig[i]),
         .len    (len[i*CNT_W +: CNT_W]),
         .retrig (retrig[i]),
         .flush  (flush),
         .hold   (hold[i]),
         .done   (done[i])
      );
   end

   assign hold_any = |hold;

endmodule
